// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg: shared state encoding and defaults for the SRAM data-memory controller
package sram_controller_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_t;
  localparam int DATA_W = 16;
  localparam int DEF_WAIT = 5;
  localparam int DEF_BASE = 1024;
endpackage

// File: rtl/sram_controller_wait_counter.sv
// wait_counter: 4-bit phase counter that clears itself at its terminal count WAIT_CYCLES-1
module wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] cnt,
  output logic       tc
);
  assign tc = en && cnt == 4'(WAIT_CYCLES - 1);
  always_ff @(posedge clk)
    cnt <= (rst || tc) ? '0 : en ? cnt + 4'd1 : cnt;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: moves 32-bit MEM-stage accesses as two fixed-wait halfword accesses on a 16-bit async SRAM
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT,
  parameter int MEM_BASE    = DEF_BASE,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [DATA_W-1:0]  sram_dq_in,
  output logic               sram_we_n
);
  localparam logic [3:0] PRE = 4'(WAIT_CYCLES - 2);
  state_t state;
  logic op_wr, tc, busy, unused_bits;
  logic [SRAM_AW-2:0] hw;
  logic [DATA_W-1:0] wr_hi;
  logic [3:0] cnt;
  logic [31:0] off;
  assign off = address - 32'(MEM_BASE);
  assign unused_bits = ^{off[31:SRAM_AW+1], off[1:0]};
  assign busy = state == LOW || state == HIGH;
  assign ready = (state == IDLE && !(wr_en || rd_en)) || state == DONE;
  wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .clk(clk),
    .rst(rst),
    .en(busy),
    .cnt(cnt),
    .tc(tc)
  );
  // strobes are registered one edge ahead so we_n rises on the last phase cycle for data hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      op_wr       <= 1'b0;
      hw          <= '0;
      wr_hi       <= '0;
    end else begin
      case (state)
        IDLE: if (wr_en || rd_en) begin
          state       <= LOW;
          op_wr       <= wr_en;
          hw          <= off[SRAM_AW:2];
          wr_hi       <= write_data[31:16];
          sram_addr   <= {off[SRAM_AW:2], 1'b0};
          sram_dq_out <= write_data[15:0];
          sram_dq_oe  <= wr_en;
          sram_we_n   <= !wr_en;
        end
        LOW: if (tc) begin
          state       <= HIGH;
          read_data[15:0] <= op_wr ? read_data[15:0] : sram_dq_in;
          sram_addr   <= {hw, 1'b1};
          sram_dq_out <= wr_hi;
          sram_we_n   <= !op_wr;
        end else if (cnt == PRE) sram_we_n <= 1'b1;
        HIGH: if (tc) begin
          state       <= DONE;
          read_data[31:16] <= op_wr ? read_data[31:16] : sram_dq_in;
          sram_dq_oe  <= 1'b0;
          sram_we_n   <= 1'b1;
        end else if (cnt == PRE) sram_we_n <= 1'b1;
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: table-driven accesses against behavioural SRAMs, with a read-data scoreboard
module tb_sram_controller;
  logic clk = 0, rst = 1, rst2 = 1;
  always #5 clk = ~clk;

  logic wr_en = 0, rd_en = 0, ready, oe, we_n;
  logic [31:0] address = 0, write_data = 0, read_data;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;

  logic wr2 = 0, rd2 = 0, ready2, oe2, we_n2;
  logic [31:0] addr2 = 0, wdata2 = 0, rdata2;
  logic [17:0] sram_addr2;
  logic [15:0] dq_out2, dq_in2;

  sram_controller dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_oe(oe),
    .sram_dq_in(dq_in), .sram_we_n(we_n)
  );
  sram_controller #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2), .wr_en(wr2), .rd_en(rd2), .address(addr2),
    .write_data(wdata2), .read_data(rdata2), .ready(ready2),
    .sram_addr(sram_addr2), .sram_dq_out(dq_out2), .sram_dq_oe(oe2),
    .sram_dq_in(dq_in2), .sram_we_n(we_n2)
  );

  // SRAM models: write on the we_n rising edge using the bus values held while we_n was low
  logic [15:0] mem1 [0:65535] = '{default: 16'h0};
  logic [15:0] mem2 [0:65535] = '{default: 16'h0};
  logic we_d1 = 1, we_d2 = 1;
  logic [15:0] a_d1 = 0, dq_d1 = 0, a_d2 = 0, dq_d2 = 0;
  assign dq_in  = mem1[sram_addr[15:0]];
  assign dq_in2 = mem2[sram_addr2[15:0]];
  always @(negedge clk) begin
    if (!we_d1 && we_n) mem1[a_d1] <= dq_d1;
    we_d1 <= we_n; a_d1 <= sram_addr[15:0]; dq_d1 <= dq_out;
  end
  always @(negedge clk) begin
    if (!we_d2 && we_n2) mem2[a_d2] <= dq_d2;
    we_d2 <= we_n2; a_d2 <= sram_addr2[15:0]; dq_d2 <= dq_out2;
  end

  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] exp_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int hw_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return int'({o[16:2], 1'b0});
  endfunction

  // starts #1 after a posedge; returns #1 after the posedge that leaves DONE
  task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output int welow);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    if (wr) shadow[a] = d;
    else exp_rd = shadow.exists(a) ? shadow[a] : 32'h0;
    exp_q.push_back(exp_rd);
    lat = -1; welow = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!we_n) welow++;
      if (ready) begin lat = c; break; end
    end
    check("read_data at done", read_data, exp_q.pop_front());
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0;
  endtask

  task automatic access2(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int welow);
    wr2 = wr; rd2 = !wr; addr2 = a; wdata2 = d;
    lat = -1; welow = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!we_n2) welow++;
      if (ready2) begin lat = c; break; end
    end
    @(posedge clk); #1;
    wr2 = 0; rd2 = 0;
  endtask

  typedef struct {
    bit wr;
    bit rd;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;
  vec_t vt[9];

  initial begin
    int lat, welow, h, rc;
    vt = '{
      '{1'b1, 1'b0, 32'd1024, 32'hDEADBEEF},
      '{1'b0, 1'b1, 32'd1024, 32'h0},
      '{1'b1, 1'b0, 32'd1028, 32'h12345678},
      '{1'b0, 1'b1, 32'd1028, 32'h0},
      '{1'b1, 1'b1, 32'd1036, 32'hA5A55A5A},
      '{1'b0, 1'b1, 32'd1036, 32'h0},
      '{1'b1, 1'b0, 32'd0,    32'h0F0F1234},
      '{1'b0, 1'b1, 32'd0,    32'h0},
      '{1'b0, 1'b1, 32'd1024, 32'h0}
    };
    // reset with a write request pending
    wr_en = 1; address = 32'd1100; write_data = 32'h0;
    @(posedge clk); @(negedge clk);
    check("reset we_n", 32'(we_n), 32'h1);
    check("reset oe", 32'(oe), 32'h0);
    check("reset read_data", read_data, 32'h0);
    check("reset sram_addr", 32'(sram_addr), 32'h0);
    @(posedge clk); #1 rst = 0; rst2 = 0;
    @(negedge clk);
    check("ready with pending request", 32'(ready), 32'h0);
    rc = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ready) begin rc = c; break; end
    end
    check("reset-pending write latency", 32'(rc), 32'd10);
    shadow[32'd1100] = 32'h0;
    @(posedge clk); #1 wr_en = 0;

    for (int i = 0; i < 9; i++) begin
      access(vt[i].wr, vt[i].rd, vt[i].a, vt[i].d, lat, welow);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd11);
      if (vt[i].wr) begin
        h = hw_of(vt[i].a);
        check($sformatf("vec%0d low hw", i), 32'(mem1[h]), 32'(vt[i].d[15:0]));
        check($sformatf("vec%0d high hw", i), 32'(mem1[h + 1]), 32'(vt[i].d[31:16]));
        check($sformatf("vec%0d we_n low cycles", i), 32'(welow), 32'd8);
      end else check($sformatf("vec%0d no write strobe", i), 32'(welow), 32'd0);
    end
    check("sram[0]", 32'(mem1[0]), 32'h0000BEEF);
    check("sram[1]", 32'(mem1[1]), 32'h0000DEAD);

    // reset during cycle 3 of the LOW write phase
    h = hw_of(32'd1040);
    wr_en = 1; address = 32'd1040; write_data = 32'hCAFEF00D;
    repeat (4) @(posedge clk);
    #1 rst = 1; wr_en = 0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("abort we_n", 32'(we_n), 32'h1);
    check("abort oe", 32'(oe), 32'h0);
    check("abort idle ready", 32'(ready), 32'h1);
    repeat (12) @(negedge clk);
    check("abort high never written", 32'(mem1[h + 1]), 32'h0);
    check("abort ready stays", 32'(ready), 32'h1);
    @(posedge clk); #1;
    exp_rd = 0;
    access(1'b0, 1'b1, 32'd1028, 32'h0, lat, welow);
    check("post-abort read latency", 32'(lat), 32'd11);

    // short wait-state build
    access2(1'b1, 32'd1032, 32'h0BADF00D, lat, welow);
    check("w2 write latency", 32'(lat), 32'd5);
    check("w2 we_n low cycles", 32'(welow), 32'd2);
    access2(1'b0, 32'd1032, 32'h0, lat, welow);
    check("w2 read latency", 32'(lat), 32'd5);
    check("w2 read data", rdata2, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
